// File: rtl/ppi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppi_pkg
// Description : Shared types and constants for the 8255 PPI host-side bus
//               sequencer: FSM state encoding, PPI register addresses, the
//               default control word and the illegal-read return value.
// Macros      : PPI_INIT_EN adds the INIT state to the state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ppi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4
`ifdef PPI_INIT_EN
        ,
        ST_INIT    = 3'd5
`endif
    } ppi_state_t;

    localparam logic [1:0] PPI_ADDR_A    = 2'd0;
    localparam logic [1:0] PPI_ADDR_B    = 2'd1;
    localparam logic [1:0] PPI_ADDR_C    = 2'd2;
    localparam logic [1:0] PPI_ADDR_CTRL = 2'd3;

    // Mode 0, all ports input: the 8255's own power-on configuration
    localparam logic [7:0] PPI_DEFAULT_CTRL  = 8'h9B;
    localparam logic [7:0] PPI_ILLEGAL_RDATA = 8'h00;

    function automatic int ppi_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppi_bus_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module      : ppi_cycle_timer
// Description : Loadable down-counter timing every bus-cycle phase. Load the
//               phase length minus one on phase entry; done is high in the
//               last cycle of the phase.
// Ports       : clk, reset (sync, active-high), load, load_val[CNT_W], done
// Revision    : 1.0 - initial release
// ============================================================================
module ppi_cycle_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ppi_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ppi_bus_ctrl
// Description : Host-side bus-cycle sequencer for the 8255 PPI. Turns
//               valid/ready byte commands into timed setup/strobe/hold/
//               recover bus cycles and returns read data as a one-cycle
//               response pulse. All PPI pins are driven from registers.
// Ports       : clk, reset (sync, active-high)
//               cmd_valid/cmd_ready/cmd_wr/cmd_addr[2]/cmd_wdata[8]
//               rsp_valid/rsp_rdata[8]
//               data_wire[8] (inout), address[2], chip_select (low),
//               read (low), write (low)
// Macros      : PPI_INIT_EN - write INIT_CTRL to the control register once
//               after reset before accepting host commands.
// Revision    : 1.0 - initial release
// ============================================================================
module ppi_bus_ctrl
    import ppi_pkg::*;
#(
    parameter int         SETUP_CYCLES   = 1,
    parameter int         STROBE_CYCLES  = 2,
    parameter int         RECOVER_CYCLES = 1,
    parameter logic [7:0] INIT_CTRL      = PPI_DEFAULT_CTRL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_wr,
    input  logic [1:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    inout  wire  [7:0] data_wire,
    output logic [1:0] address,
    output logic       chip_select,
    output logic       read,
    output logic       write
);

    localparam int CNT_W = $clog2(ppi_max3(SETUP_CYCLES, STROBE_CYCLES, RECOVER_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] C_SETUP_LD   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_STROBE_LD  = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_RECOVER_LD = CNT_W'(RECOVER_CYCLES - 1);

    ppi_state_t       r_state;
    ppi_state_t       w_state_nxt;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_tmr_done;

    // Latched command
    logic       r_wr;
    logic [1:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_illegal;

    // Registered pin/handshake outputs
    logic       r_cs_n;
    logic       r_rd_n;
    logic       r_wr_n;
    logic       r_oe;
    logic       r_ready;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_rdata;

    logic       w_accept;
    logic       w_init_go;
    logic       w_ld;
    logic       w_ld_wr;
    logic [1:0] w_ld_addr;
    logic [7:0] w_ld_wdata;
    logic       w_nxt_wr;
    logic       w_nxt_ill;
    logic       w_nxt_active;
    logic       w_sample;

`ifdef PPI_INIT_EN
    logic r_init_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_init_pending <= 1'b1;
        end else if (r_state == ST_INIT) begin
            r_init_pending <= 1'b0;
        end
    end

    assign w_init_go = (r_state == ST_INIT);
`else
    assign w_init_go = 1'b0;
`endif

    assign w_accept = (r_state == ST_IDLE) && cmd_valid && r_ready;

    // INIT and a host accept share one command-load path into SETUP
    assign w_ld       = w_accept || w_init_go;
    assign w_ld_wr    = w_init_go ? 1'b1          : cmd_wr;
    assign w_ld_addr  = w_init_go ? PPI_ADDR_CTRL : cmd_addr;
    assign w_ld_wdata = w_init_go ? INIT_CTRL     : cmd_wdata;

    // Outputs are registered from next-state so the pins never glitch
    assign w_nxt_wr     = w_ld ? w_ld_wr : r_wr;
    assign w_nxt_ill    = w_ld ? (!w_ld_wr && (w_ld_addr == PPI_ADDR_CTRL)) : r_illegal;
    assign w_nxt_active = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_STROBE) ||
                          (w_state_nxt == ST_HOLD);
    assign w_sample     = (r_state == ST_STROBE) && (w_state_nxt == ST_HOLD) && !r_wr;

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        case (r_state)
            ST_IDLE: begin
`ifdef PPI_INIT_EN
                if (r_init_pending) begin
                    w_state_nxt = ST_INIT;
                end else
`endif
                if (w_accept) begin
                    w_state_nxt = ST_SETUP;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = C_SETUP_LD;
                end
            end
`ifdef PPI_INIT_EN
            ST_INIT: begin
                w_state_nxt = ST_SETUP;
                w_tmr_load  = 1'b1;
                w_tmr_val   = C_SETUP_LD;
            end
`endif
            ST_SETUP: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_STROBE;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = C_STROBE_LD;
                end
            end
            ST_STROBE: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_HOLD;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = '0;
                end
            end
            ST_HOLD: begin
                w_state_nxt = ST_RECOVER;
                w_tmr_load  = 1'b1;
                w_tmr_val   = C_RECOVER_LD;
            end
            ST_RECOVER: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wr        <= 1'b0;
            r_addr      <= 2'b00;
            r_wdata     <= 8'h00;
            r_illegal   <= 1'b0;
            r_cs_n      <= 1'b1;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_oe        <= 1'b0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_ld) begin
                r_wr      <= w_ld_wr;
                r_addr    <= w_ld_addr;
                r_wdata   <= w_ld_wdata;
                r_illegal <= !w_ld_wr && (w_ld_addr == PPI_ADDR_CTRL);
            end
            // An illegal control-register read keeps the bus fully idle
            r_cs_n      <= !(w_nxt_active && !w_nxt_ill);
            r_rd_n      <= !((w_state_nxt == ST_STROBE) && !w_nxt_wr && !w_nxt_ill);
            r_wr_n      <= !((w_state_nxt == ST_STROBE) && w_nxt_wr);
            r_oe        <= w_nxt_active && w_nxt_wr;
            r_ready     <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= w_sample;
            if (w_sample) begin
                r_rsp_rdata <= r_illegal ? PPI_ILLEGAL_RDATA : data_wire;
            end
        end
    end

    ppi_cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .done     (w_tmr_done)
    );

    assign data_wire   = r_oe ? r_wdata : 8'bzzzz_zzzz;
    assign address     = r_addr;
    assign chip_select = r_cs_n;
    assign read        = r_rd_n;
    assign write       = r_wr_n;
    assign cmd_ready   = r_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ppi_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppi_bus_ctrl
// Description : Self-checking bench for ppi_bus_ctrl (default build). A
//               stimulus process issues directed commands and queues their
//               expected bus cycles and read responses; a monitor process
//               checks the pins per cycle and pops responses on rsp_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppi_bus_ctrl;

    typedef struct packed {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
    } cmd_t;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_wr    = 1'b0;
    logic [1:0] cmd_addr  = 2'd0;
    logic [7:0] cmd_wdata = 8'h00;
    wire        cmd_ready;
    wire        rsp_valid;
    wire  [7:0] rsp_rdata;
    wire  [7:0] data_wire;
    wire  [1:0] address;
    wire        chip_select;
    wire        read;
    wire        write;

    logic [7:0] model_data = 8'h00;

    int   errors    = 0;
    int   checks    = 0;
    int   cyc       = 0;
    int   rsp_count = 0;
    int   off       = 0;
    bit   active    = 1'b0;
    bit   rst_prev  = 1'b0;
    cmd_t cur;

    cmd_t       exp_cmd_q[$];
    logic [7:0] exp_rsp_q[$];
    int         acc_q[$];

    ppi_bus_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_wr      (cmd_wr),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .data_wire   (data_wire),
        .address     (address),
        .chip_select (chip_select),
        .read        (read),
        .write       (write)
    );

    always #5 clk = ~clk;

    // 8255 model: drives its read data while selected and read is low
    assign data_wire = (!read && !chip_select) ? model_data : 8'bzzzz_zzzz;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Expected pins at cycle offset 'off' after the accept edge
    task automatic check_phase();
        bit   legal;
        logic e_cs, e_rd, e_wr;
        legal = cur.wr || (cur.addr != 2'd3);
        e_cs  = (off >= 1 && off <= 4 && legal) ? 1'b0 : 1'b1;
        e_rd  = ((off == 2 || off == 3) && legal && !cur.wr) ? 1'b0 : 1'b1;
        e_wr  = ((off == 2 || off == 3) && cur.wr) ? 1'b0 : 1'b1;
        chk("chip_select", chip_select, e_cs);
        chk("read", read, e_rd);
        chk("write", write, e_wr);
        chk("cmd_ready", cmd_ready, (off == 6));
        chk("rsp_valid", rsp_valid, (off == 4 && !cur.wr));
        if (!e_cs) chk("address", address, cur.addr);
        if (cur.wr && off >= 1 && off <= 4) chk("wdata", data_wire, cur.data);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_prev) begin
            chk("rst_cs", chip_select, 1);
            chk("rst_read", read, 1);
            chk("rst_write", write, 1);
            chk("rst_ready", cmd_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rdata", rsp_rdata, 0);
            chk("rst_address", address, 0);
        end else if (!reset) begin
            chk("strobe_excl", (!read && !write), 0);
            chk("strobe_no_cs", ((!read || !write) && chip_select), 0);
            if (active) begin
                off++;
                check_phase();
                if (off == 6) active = 1'b0;
            end else begin
                chk("idle_cs", chip_select, 1);
                chk("idle_read", read, 1);
                chk("idle_write", write, 1);
                chk("idle_ready", cmd_ready, 1);
                chk("idle_rsp", rsp_valid, 0);
            end
            if (rsp_valid) begin
                rsp_count++;
                if (exp_rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp (cycle %0d): got rdata %0h, expected no response", cyc, rsp_rdata);
                end else begin
                    chk("rsp_rdata", rsp_rdata, exp_rsp_q.pop_front());
                end
            end
            if (cmd_valid && cmd_ready) begin
                acc_q.push_back(cyc);
                if (exp_cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept (cycle %0d): got accept, expected none", cyc);
                end else begin
                    cur    = exp_cmd_q.pop_front();
                    active = 1'b1;
                    off    = 0;
                end
            end
        end
        if (reset) begin
            active = 1'b0;
            exp_cmd_q.delete();
            exp_rsp_q.delete();
        end
        rst_prev = reset;
    end

    // Called at posedge+1; returns at posedge+1 right after the accept edge
    task automatic issue(input logic wr, input logic [1:0] a, input logic [7:0] d,
                         input bit want_rsp, input logic [7:0] rd);
        cmd_t c;
        c.wr   = wr;
        c.addr = a;
        c.data = d;
        exp_cmd_q.push_back(c);
        if (want_rsp) exp_rsp_q.push_back(rd);
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no cmd_ready in 50 cycles, expected accept");
        cmd_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle_cycles(3);

        // Write A = 5A
        issue(1'b1, 2'd0, 8'h5A, 1'b0, 8'h00);
        idle_cycles(8);

        // Read B, model returns C3
        model_data = 8'hC3;
        issue(1'b0, 2'd1, 8'h00, 1'b1, 8'hC3);
        idle_cycles(8);

        // Illegal read of the control register returns 00 with a quiet bus
        model_data = 8'hE7;
        issue(1'b0, 2'd3, 8'h00, 1'b1, 8'h00);
        idle_cycles(8);

        // Back-to-back with cmd_valid held high
        model_data = 8'h77;
        acc_q.delete();
        issue(1'b1, 2'd2, 8'h11, 1'b0, 8'h00);
        issue(1'b0, 2'd0, 8'h00, 1'b1, 8'h77);
        issue(1'b1, 2'd1, 8'h22, 1'b0, 8'h00);
        idle_cycles(8);
        chk("b2b_accepts", acc_q.size(), 3);
        for (int i = 1; i < acc_q.size(); i++) chk("b2b_gap", acc_q[i] - acc_q[i-1], 6);

        // Reset during STROBE drops the read: no response may appear
        model_data = 8'h99;
        issue(1'b0, 2'd0, 8'h00, 1'b0, 8'h00);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle_cycles(4);

        // Normal operation after the aborted cycle
        issue(1'b1, 2'd0, 8'h3C, 1'b0, 8'h00);
        idle_cycles(8);

        chk("rsp_total", rsp_count, 3);
        chk("rsp_queue_empty", exp_rsp_q.size(), 0);
        chk("cmd_queue_empty", exp_cmd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
